// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: register index, hazard-unit FSM states and
// the bundle of stage-control strobes the hazard unit drives.
package lc3b_types;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    IMISS  = 2'd1,
    DMISS  = 2'd2,
    IDRAIN = 2'd3
  } hcu_state_t;

  localparam int unsigned HCU_CNT_W = 16;

  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
    logic not_stall;
    logic load_tgt;
    logic pc_redirect_sel;
  } hcu_ctrl_t;

  // Every stage frozen; IF/ID is not stalled by a hazard, merely not loaded.
  function automatic hcu_ctrl_t hcu_ctrl_freeze();
    hcu_ctrl_t c;
    c           = '0;
    c.not_stall = 1'b1;
    return c;
  endfunction

  // Every stage advances with real data.
  function automatic hcu_ctrl_t hcu_ctrl_advance();
    hcu_ctrl_t c;
    c             = '0;
    c.load_pc     = 1'b1;
    c.load_if_id  = 1'b1;
    c.load_id_ex  = 1'b1;
    c.load_ex_mem = 1'b1;
    c.load_mem_wb = 1'b1;
    c.not_stall   = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds a
// source operand of the instruction currently in ID.
module hazard_detect
  import lc3b_types::*;
(
  input  logic    ex_is_load_i,
  input  lc3b_reg ex_dest_i,
  input  lc3b_reg id_src1_i,
  input  lc3b_reg id_src2_i,
  input  logic    id_uses_src2_i,
  output logic    load_use_o
);

  logic src1_hit;
  logic src2_hit;

  assign src1_hit   = (ex_dest_i == id_src1_i);
  assign src2_hit   = id_uses_src2_i && (ex_dest_i == id_src2_i);
  assign load_use_o = ex_is_load_i && (src1_hit || src2_hit);

endmodule

// File: rtl/hazard_control_unit.sv
// LC-3b pipeline hazard/stall controller: cache-miss FSM, redirect flushes and
// load-use bubbles. Optional perf counters under `HCU_PERF_COUNTERS_EN`.
module hazard_control_unit
  import lc3b_types::*;
(
  input  logic    clk,
  input  logic    reset_n,
  output logic    icache_read,
  input  logic    icache_resp,
  input  logic    dcache_req,
  input  logic    dcache_resp,
  input  logic    br_taken,
  input  lc3b_reg id_src1,
  input  lc3b_reg id_src2,
  input  logic    id_uses_src2,
  input  lc3b_reg ex_dest,
  input  logic    ex_is_load,
  output logic    load_pc,
  output logic    load_if_id,
  output logic    load_id_ex,
  output logic    load_ex_mem,
  output logic    load_mem_wb,
  output logic    flush_if_id,
  output logic    flush_id_ex,
  output logic    flush_ex_mem,
  output logic    not_stall,
  output logic    load_tgt,
  output logic    pc_redirect_sel
`ifdef HCU_PERF_COUNTERS_EN
  ,
  output logic [HCU_CNT_W-1:0] stall_cycles,
  output logic [HCU_CNT_W-1:0] flush_count
`endif
);

  hcu_state_t state_q, state_d;
  logic       rst_q;
  logic       ignore_q;
  hcu_ctrl_t  ctrl;
  logic       load_use;
  logic       dmiss_ev;
  logic       fetch_ok;
  logic       redirect_ev;

  hazard_detect u_hazard_detect (
    .ex_is_load_i   (ex_is_load),
    .ex_dest_i      (ex_dest),
    .id_src1_i      (id_src1),
    .id_src2_i      (id_src2),
    .id_uses_src2_i (id_uses_src2),
    .load_use_o     (load_use)
  );

  assign dmiss_ev = dcache_req && !dcache_resp;
  // A fetch response is only trusted once the stale post-reset one has been dropped.
  assign fetch_ok = icache_resp && !ignore_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= RUN;
      rst_q    <= 1'b1;
      ignore_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      rst_q    <= 1'b0;
      if (!rst_q && icache_resp) ignore_q <= 1'b0;
    end
  end

  always_comb begin
    ctrl        = '0;
    state_d     = state_q;
    icache_read = 1'b1;
    redirect_ev = 1'b0;
    if (rst_q) begin
      icache_read = 1'b0;
      state_d     = RUN;
    end else if (dmiss_ev) begin
      ctrl    = hcu_ctrl_freeze();
      state_d = DMISS;
    end else if (state_q == IDRAIN) begin
      // Wrong-path fetch in flight: inject bubbles until it returns, then jump.
      ctrl             = hcu_ctrl_advance();
      ctrl.flush_if_id = 1'b1;
      if (icache_resp) begin
        ctrl.pc_redirect_sel = 1'b1;
        state_d              = RUN;
      end else begin
        ctrl.load_pc = 1'b0;
      end
    end else if (br_taken) begin
      redirect_ev       = 1'b1;
      ctrl              = hcu_ctrl_advance();
      ctrl.flush_if_id  = 1'b1;
      ctrl.flush_id_ex  = 1'b1;
      ctrl.flush_ex_mem = 1'b1;
      if (fetch_ok) begin
        state_d = RUN;
      end else begin
        ctrl.load_pc  = 1'b0;
        ctrl.load_tgt = 1'b1;
        state_d       = IDRAIN;
      end
    end else if (load_use) begin
      ctrl             = hcu_ctrl_advance();
      ctrl.load_pc     = 1'b0;
      ctrl.load_if_id  = 1'b0;
      ctrl.flush_id_ex = 1'b1;
      ctrl.not_stall   = 1'b0;
      state_d          = icache_resp ? RUN : IMISS;
    end else if (fetch_ok) begin
      ctrl    = hcu_ctrl_advance();
      state_d = RUN;
    end else begin
      ctrl             = hcu_ctrl_advance();
      ctrl.load_pc     = 1'b0;
      ctrl.flush_if_id = 1'b1;
      state_d          = icache_resp ? RUN : IMISS;
    end
  end

  assign load_pc         = ctrl.load_pc;
  assign load_if_id      = ctrl.load_if_id;
  assign load_id_ex      = ctrl.load_id_ex;
  assign load_ex_mem     = ctrl.load_ex_mem;
  assign load_mem_wb     = ctrl.load_mem_wb;
  assign flush_if_id     = ctrl.flush_if_id;
  assign flush_id_ex     = ctrl.flush_id_ex;
  assign flush_ex_mem    = ctrl.flush_ex_mem;
  assign not_stall       = ctrl.not_stall;
  assign load_tgt        = ctrl.load_tgt;
  assign pc_redirect_sel = ctrl.pc_redirect_sel;

`ifdef HCU_PERF_COUNTERS_EN
  logic [HCU_CNT_W-1:0] stall_q;
  logic [HCU_CNT_W-1:0] flush_q;

  function automatic logic [HCU_CNT_W-1:0] sat_inc(input logic [HCU_CNT_W-1:0] v);
    return (v == {HCU_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!rst_q && (!ctrl.not_stall || dmiss_ev)) stall_q <= sat_inc(stall_q);
      if (redirect_ev) flush_q <= sat_inc(flush_q);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit; perf-counter checks compile in only
// when HCU_PERF_COUNTERS_EN is defined.
module tb_hazard_control_unit;
  import lc3b_types::*;

  logic    clk = 1'b0;
  logic    reset_n;
  logic    icache_read, icache_resp, dcache_req, dcache_resp, br_taken;
  lc3b_reg id_src1, id_src2, ex_dest;
  logic    id_uses_src2, ex_is_load;
  logic    load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic    flush_if_id, flush_id_ex, flush_ex_mem;
  logic    not_stall, load_tgt, pc_redirect_sel;
`ifdef HCU_PERF_COUNTERS_EN
  logic [15:0] stall_cycles, flush_count;
`endif

  always #5 clk = ~clk;

  hazard_control_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .icache_read     (icache_read),
    .icache_resp     (icache_resp),
    .dcache_req      (dcache_req),
    .dcache_resp     (dcache_resp),
    .br_taken        (br_taken),
    .id_src1         (id_src1),
    .id_src2         (id_src2),
    .id_uses_src2    (id_uses_src2),
    .ex_dest         (ex_dest),
    .ex_is_load      (ex_is_load),
    .load_pc         (load_pc),
    .load_if_id      (load_if_id),
    .load_id_ex      (load_id_ex),
    .load_ex_mem     (load_ex_mem),
    .load_mem_wb     (load_mem_wb),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .flush_ex_mem    (flush_ex_mem),
    .not_stall       (not_stall),
    .load_tgt        (load_tgt),
    .pc_redirect_sel (pc_redirect_sel)
`ifdef HCU_PERF_COUNTERS_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
`endif
  );

  // {icache_read, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
  //  flush_if_id, flush_id_ex, flush_ex_mem, not_stall, load_tgt, pc_redirect_sel}
  logic [11:0] outs;
  assign outs = {icache_read, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                 flush_if_id, flush_id_ex, flush_ex_mem, not_stall, load_tgt, pc_redirect_sel};

  localparam logic [11:0] P_RST = 12'b0000_0000_0000;
  localparam logic [11:0] P_RUN = 12'b1111_1100_0100;
  localparam logic [11:0] P_DST = 12'b1000_0000_0100;
  localparam logic [11:0] P_LU  = 12'b1001_1101_0000;
  localparam logic [11:0] P_IMS = 12'b1011_1110_0100;
  localparam logic [11:0] P_BRH = 12'b1111_1111_1100;
  localparam logic [11:0] P_BRM = 12'b1011_1111_1110;
  localparam logic [11:0] P_IDR = 12'b1111_1110_0101;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 with inputs already set; samples at the falling edge.
  task automatic vec(input string tag, input logic [11:0] exp);
    #4;
    chk(tag, {20'd0, outs}, {20'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; icache_resp = 1'b1; dcache_req = 1'b0; dcache_resp = 1'b0;
    br_taken = 1'b0; id_src1 = 3'd2; id_src2 = 3'd3; id_uses_src2 = 1'b1;
    ex_dest = 3'd2; ex_is_load = 1'b0;
    @(posedge clk); #1;
    vec("rst0", P_RST);
    vec("rst1", P_RST);
    reset_n = 1'b1;
    vec("rst_release", P_RST);
    icache_resp = 1'b0;
    vec("post_rst_fetch", P_IMS);
    icache_resp = 1'b1;
    vec("stale_drop", P_IMS);

    for (int i = 0; i < 3; i++) begin
      id_src1 = 3'(i); id_src2 = 3'(i + 4); ex_dest = 3'(i);
      vec($sformatf("straight%0d", i), P_RUN);
    end

    ex_is_load = 1'b1; ex_dest = 3'd1; id_src1 = 3'd1; id_src2 = 3'd3; id_uses_src2 = 1'b1;
    vec("lu_src1", P_LU);
    ex_is_load = 1'b0;
    vec("lu_after", P_RUN);
    ex_is_load = 1'b1; ex_dest = 3'd3;
    vec("lu_src2", P_LU);
    id_uses_src2 = 1'b0;
    vec("lu_imm_nohaz", P_RUN);
    ex_is_load = 1'b0; id_uses_src2 = 1'b1;

    dcache_req = 1'b1;
    for (int i = 0; i < 5; i++) vec($sformatf("dmiss%0d", i), P_DST);
    dcache_resp = 1'b1;
    vec("dmiss_resp", P_RUN);
`ifdef HCU_PERF_COUNTERS_EN
    chk("stall_cycles", {16'd0, stall_cycles}, 32'd7);
`endif
    dcache_req = 1'b0; dcache_resp = 1'b0;
    vec("post_dmiss", P_RUN);

    br_taken = 1'b1;
    vec("br_hit", P_BRH);
    br_taken = 1'b0;
    vec("br_hit_after", P_RUN);

    br_taken = 1'b1; icache_resp = 1'b0;
    vec("br_miss", P_BRM);
    br_taken = 1'b0;
    for (int i = 0; i < 3; i++) vec($sformatf("idrain%0d", i), P_IMS);
    icache_resp = 1'b1;
    vec("idrain_resp", P_IDR);
    vec("idrain_done", P_RUN);

    icache_resp = 1'b0;
    vec("imiss0", P_IMS);
    vec("imiss1", P_IMS);
    icache_resp = 1'b1;
    vec("imiss_resp", P_RUN);

    br_taken = 1'b1; dcache_req = 1'b1;
    vec("br_dmiss0", P_DST);
    vec("br_dmiss1", P_DST);
    dcache_resp = 1'b1;
    vec("br_dmiss_resp", P_BRH);
    br_taken = 1'b0; dcache_req = 1'b0; dcache_resp = 1'b0;
    vec("br_dmiss_after", P_RUN);

    br_taken = 1'b1; ex_is_load = 1'b1; ex_dest = 3'd5; id_src1 = 3'd5;
    vec("br_over_lu", P_BRH);
    br_taken = 1'b0; ex_is_load = 1'b0;
`ifdef HCU_PERF_COUNTERS_EN
    chk("flush_count", {16'd0, flush_count}, 32'd4);
`endif

    dcache_req = 1'b1; icache_resp = 1'b0;
    vec("dmiss_over_imiss", P_DST);
    dcache_req = 1'b0; icache_resp = 1'b1;
    vec("dmiss_over_imiss_exit", P_RUN);

    dcache_req = 1'b1;
    vec("mid_dmiss0", P_DST);
    vec("mid_dmiss1", P_DST);
    reset_n = 1'b0;
    vec("rst_edge_pending", P_DST);
`ifdef HCU_PERF_COUNTERS_EN
    chk("stall_after_rst", {16'd0, stall_cycles}, 32'd0);
    chk("flush_after_rst", {16'd0, flush_count}, 32'd0);
`endif
    vec("rst_mid_dmiss", P_RST);
    reset_n = 1'b1; dcache_req = 1'b0;
    vec("rst2_release", P_RST);
    vec("rst2_stale_drop", P_IMS);
    vec("rst2_run", P_RUN);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
